// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, mid-bit sampling points
// and the 2-of-3 majority helper used by the receiver's bit voter.
package uart_rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int SAMPLE_LO      = 7;
    localparam int SAMPLE_MID     = 8;
    localparam int SAMPLE_HI      = 9;

    // Last tick index of a bit period for a given oversampling ratio.
    function automatic int tick_last(input int os);
        return os - 1;
    endfunction

    localparam int TICK_LAST = tick_last(OVERSAMPLE_DEF);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART receive-side bundle.
//   b_tick    : oversampling tick (master -> slave)
//   rx        : serial line, idle high (master -> slave)
//   rx_data   : last good byte (slave -> master)
//   rx_done   : 1-clk strobe, rx_data updated (slave -> master)
//   frame_err : 1-clk strobe, stop bit sampled low (slave -> master)
//   rx_busy   : receiver not idle (slave -> master)
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = 8
);
    logic                 b_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output b_tick, rx,
        input  rx_data, rx_done, frame_err, rx_busy
    );

    modport slave (
        input  b_tick, rx,
        output rx_data, rx_done, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clk : sampling clock
//   rst : synchronous active-low reset, flops reset to 1 (line idle level)
//   d_i : asynchronous input
//   q_o : synchronised output, STAGES clk of latency
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled via b_tick, LSB first.
// Each bit is decided by a 2-of-3 vote of samples taken at ticks 7, 8, 9.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : uart_rx_if slave (b_tick, rx in; rx_data, rx_done, frame_err, rx_busy out)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LO   = TW'(SAMPLE_LO);
    localparam logic [TW-1:0] T_MID  = TW'(SAMPLE_MID);
    localparam logic [TW-1:0] T_HI   = TW'(SAMPLE_HI);
    localparam logic [TW-1:0] T_LAST = TW'(tick_last(OVERSAMPLE));
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    logic [1:0]           state_q,  state_d;
    logic [TW-1:0]        tick_q,   tick_d;
    logic [BW-1:0]        bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 smp_lo_q, smp_lo_d;
    logic                 smp_mid_q, smp_mid_d;
    logic                 done_q,   done_d;
    logic                 ferr_q,   ferr_d;
    logic                 vote;

    // The third sample is the live rx_s on the tick-9 b_tick.
    assign vote = maj3(smp_lo_q, smp_mid_q, rx_s);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        smp_lo_d  = smp_lo_q;
        smp_mid_d = smp_mid_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            // A b_tick coinciding with the start edge is deliberately not counted.
            tick_d = '0;
            if (!rx_s) state_d = ST_START;
        end else if (bus.b_tick) begin
            tick_d = tick_q + 1'b1;
            if (tick_q == T_LO)  smp_lo_d  = rx_s;
            if (tick_q == T_MID) smp_mid_d = rx_s;

            case (state_q)
                ST_START: begin
                    if (tick_q == T_HI && vote) begin
                        state_d = ST_IDLE;      // start bit was a glitch
                        tick_d  = '0;
                    end else if (tick_q == T_LAST) begin
                        state_d = ST_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (tick_q == T_HI) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (tick_q == T_LAST) begin
                        tick_d = '0;
                        if (bit_q == B_LAST) state_d = ST_STOP;
                        else                 bit_d   = bit_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (tick_q == T_HI) begin
                        if (vote) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            smp_lo_q  <= 1'b0;
            smp_mid_q <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            smp_lo_q  <= smp_lo_d;
            smp_mid_q <= smp_mid_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: the serial line is described as a list of per-b_tick
// slot levels; a protocol-level decoder turns that list into the expected
// strobes, and a per-cycle monitor compares the DUT against it.
module tb_uart_rx;

    localparam int TPER = 4;   // clk per b_tick

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        last_ev[$];
    bit         seg[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] model_data = 8'h00;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- line description ----------------
    task automatic add_bits(input bit lvl, input int n);
        for (int i = 0; i < n; i++) seg.push_back(lvl);
    endtask

    task automatic add_frame(input logic [7:0] d, input bit stop_lvl);
        add_bits(1'b0, 16);
        for (int b = 0; b < 8; b++) add_bits(d[b], 16);
        add_bits(stop_lvl, 16);
    endtask

    task automatic flip(input int idx);
        if (idx < seg.size()) seg[idx] = ~seg[idx];
    endtask

    // ---------------- behavioural reference ----------------
    function automatic bit lv(input int i);
        if (i >= 0 && i < seg.size()) return seg[i];
        return 1'b1;
    endfunction

    // Bit b of a frame whose start slot is s: majority of line at slots 7,8,9 of that bit.
    function automatic bit vote(input int s, input int b);
        int a;
        int n;
        a = s + 16 * b;
        n = int'(lv(a + 7)) + int'(lv(a + 8)) + int'(lv(a + 9));
        return n >= 2;
    endfunction

    task automatic decode_seg();
        int         k;
        int         s;
        ev_t        e;
        logic [7:0] d;
        last_ev.delete();
        k = -1;
        forever begin
            s = k + 1;
            // A line already low when the receiver goes idle restarts it on the next slot.
            if (!(k >= 0 && lv(k) == 1'b0))
                while (s < seg.size() && seg[s] == 1'b1) s++;
            if (s + 16 * 9 + 9 >= seg.size()) break;
            if (vote(s, 0)) begin
                k = s + 9;
                continue;
            end
            for (int b = 0; b < 8; b++) d[b] = vote(s, b + 1);
            e.err  = !vote(s, 9);
            e.data = d;
            last_ev.push_back(e);
            exp_q.push_back(e);
            k = s + 16 * 9 + 9;
        end
    endtask

    task automatic pin(input int idx, input bit err, input logic [7:0] d);
        if (idx < last_ev.size()) begin
            chk($sformatf("pin_err%0d", idx), 32'(last_ev[idx].err), 32'(err));
            chk($sformatf("pin_data%0d", idx), 32'(last_ev[idx].data), 32'(d));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic slot(input bit lvl);
        bus.rx     = lvl;
        bus.b_tick = 1'b0;
        repeat (TPER - 1) @(negedge clk);
        bus.b_tick = 1'b1;
        @(negedge clk);
        bus.b_tick = 1'b0;
    endtask

    task automatic drive_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) slot(seg[i]);
    endtask

    task automatic finish_seg();
        chk("exp_drained", 32'(exp_q.size()), 0);
        seg.delete();
    endtask

    task automatic run_seg();
        drive_range(0, seg.size());
        finish_seg();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && rst) begin
            if (bus.rx_done || bus.frame_err) begin
                if (bus.rx_done)   done_cnt++;
                if (bus.frame_err) ferr_cnt++;
                chk("strobe_exclusive", 32'(bus.rx_done & bus.frame_err), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, bus.frame_err, bus.rx_done}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {30'd0, bus.frame_err, bus.rx_done},
                        {30'd0, e.err, ~e.err});
                    if (!e.err) model_data = e.data;
                end
            end
            chk("rx_data", 32'(bus.rx_data), 32'(model_data));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int         d0;
        int         f0;
        int         nf;
        int         base;
        int         nflip;
        logic [7:0] rd;
        bit         stp;

        bus.rx     = 1'b1;
        bus.b_tick = 1'b0;
        rst        = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("reset_rx_data", 32'(bus.rx_data), 0);
        chk("reset_rx_done", 32'(bus.rx_done), 0);
        chk("reset_frame_err", 32'(bus.frame_err), 0);
        chk("reset_rx_busy", 32'(bus.rx_busy), 0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        add_bits(1'b1, 10);
        run_seg();

        // 0x55, 0x00, 0xFF
        d0 = done_cnt; f0 = ferr_cnt;
        add_frame(8'h55, 1'b1); add_bits(1'b1, 4);
        add_frame(8'h00, 1'b1); add_bits(1'b1, 4);
        add_frame(8'hFF, 1'b1); add_bits(1'b1, 170);
        decode_seg();
        chk("pin_count_t1", 32'(last_ev.size()), 3);
        pin(0, 1'b0, 8'h55); pin(1, 1'b0, 8'h00); pin(2, 1'b0, 8'hFF);
        run_seg();
        chk("t1_done_count", 32'(done_cnt - d0), 3);
        chk("t1_no_ferr", 32'(ferr_cnt - f0), 0);
        chk("t1_rx_data", 32'(bus.rx_data), 32'h0FF);

        // short low pulse: rejected start
        d0 = done_cnt;
        add_bits(1'b0, 3); add_bits(1'b1, 170);
        decode_seg();
        chk("pin_count_t2", 32'(last_ev.size()), 0);
        drive_range(0, 4);
        chk("t2_busy_mid", 32'(bus.rx_busy), 1);
        drive_range(4, seg.size());
        finish_seg();
        chk("t2_busy_end", 32'(bus.rx_busy), 0);
        chk("t2_no_done", 32'(done_cnt - d0), 0);
        chk("t2_rx_data", 32'(bus.rx_data), 32'h0FF);

        // stop bit forced low
        d0 = done_cnt; f0 = ferr_cnt;
        add_frame(8'hA5, 1'b0); add_bits(1'b1, 170);
        decode_seg();
        chk("pin_count_t3", 32'(last_ev.size()), 1);
        pin(0, 1'b1, 8'hA5);
        run_seg();
        chk("t3_ferr_count", 32'(ferr_cnt - f0), 1);
        chk("t3_no_done", 32'(done_cnt - d0), 0);
        chk("t3_rx_data", 32'(bus.rx_data), 32'h0FF);

        // back-to-back frames
        d0 = done_cnt;
        add_frame(8'hA5, 1'b1); add_frame(8'h3C, 1'b1); add_bits(1'b1, 170);
        decode_seg();
        chk("pin_count_t4", 32'(last_ev.size()), 2);
        pin(0, 1'b0, 8'hA5); pin(1, 1'b0, 8'h3C);
        run_seg();
        chk("t4_done_count", 32'(done_cnt - d0), 2);
        chk("t4_rx_data", 32'(bus.rx_data), 32'h03C);

        // reset during data bit 4 of 0x96
        add_frame(8'h96, 1'b1);
        drive_range(0, 16 * 5 + 4);
        chk("t5_busy_before_rst", 32'(bus.rx_busy), 1);
        rst        = 1'b0;
        model_data = 8'h00;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t5_rst_rx_data", 32'(bus.rx_data), 0);
        chk("t5_rst_rx_done", 32'(bus.rx_done), 0);
        chk("t5_rst_frame_err", 32'(bus.frame_err), 0);
        chk("t5_rst_rx_busy", 32'(bus.rx_busy), 0);
        @(negedge clk);
        rst = 1'b1;
        seg.delete();
        add_bits(1'b1, 30);
        run_seg();
        add_frame(8'h69, 1'b1); add_bits(1'b1, 170);
        decode_seg();
        pin(0, 1'b0, 8'h69);
        run_seg();
        chk("t5_rx_data", 32'(bus.rx_data), 32'h069);

        // one-tick glitch at tick 8 of data bit 2 of 0x00
        add_frame(8'h00, 1'b1);
        flip(16 * 3 + 8);
        add_bits(1'b1, 170);
        decode_seg();
        chk("pin_count_t6", 32'(last_ev.size()), 1);
        pin(0, 1'b0, 8'h00);
        run_seg();
        chk("t6_rx_data", 32'(bus.rx_data), 0);

        // break: frame error, then immediate restart on the still-low line
        d0 = done_cnt; f0 = ferr_cnt;
        add_frame(8'h00, 1'b0); add_bits(1'b0, 40); add_bits(1'b1, 170);
        decode_seg();
        chk("pin_count_brk", 32'(last_ev.size()), 2);
        pin(0, 1'b1, 8'h00); pin(1, 1'b0, 8'hFC);
        run_seg();
        chk("brk_ferr_count", 32'(ferr_cnt - f0), 1);
        chk("brk_done_count", 32'(done_cnt - d0), 1);

        // randomized frames with sample-window glitches and bad stop bits
        for (int t = 0; t < 20; t++) begin
            nf = $urandom_range(1, 3);
            add_bits(1'b1, $urandom_range(0, 5));
            for (int f = 0; f < nf; f++) begin
                base  = seg.size();
                rd    = 8'($urandom);
                stp   = ($urandom_range(0, 3) != 0);
                add_frame(rd, stp);
                nflip = $urandom_range(0, 2);
                for (int g = 0; g < nflip; g++)
                    flip(base + 16 * $urandom_range(0, 9) + $urandom_range(6, 10));
                add_bits(1'b1, $urandom_range(0, 8));
            end
            add_bits(1'b1, 170);
            decode_seg();
            run_seg();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
